v810_biu: RTL and testbench
===========================

V810_BIU -- requirements
Module: v810_biu

Interface
REQ-001 Parameter TMO_CYCLES, default 255, bus-cycle watchdog limit in CE-qualified cycles (1..65535).
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RESn  in  1  synchronous active-low reset, sampled on CLK rising edge regardless of CE.
REQ-004 CE  in  1  clock enable; when low, state, counters and registers hold and IACK/DACK are 0.
REQ-005 IA  in  32  instruction fetch address from the execution unit; bits [1:0] ignored.
REQ-006 IREQ  in  1  instruction fetch request, held with IA stable until IACK.
REQ-007 ID  out  32  instruction word, valid only while IACK=1.
REQ-008 IACK  out  1  one-cycle fetch completion.
REQ-009 DA  in  32  data address; bits [1:0] ignored.
REQ-010 DD_O  in  32  store data from the execution unit.
REQ-011 DBE  in  4  byte enables, bit i = byte lane [8i+7:8i].
REQ-012 DWR  in  1  1 = write, 0 = read.
REQ-013 DREQ  in  1  data request, held with DA/DD_O/DBE/DWR stable until DACK.
REQ-014 DD_I  out  32  load data, valid only while DACK=1.
REQ-015 DACK  out  1  one-cycle data completion.
REQ-016 A  out  32  external word address; A[1:0] always 0.
REQ-017 D_O  out  32  external write data.
REQ-018 D_I  in  32  external read data, sampled while READY=1.
REQ-019 BE  out  4  external byte enables; 4'hF on fetches.
REQ-020 WR  out  1  external write strobe.
REQ-021 BCYC  out  1  external bus cycle in progress.
REQ-022 READY  in  1  external cycle completion, may be asserted in the first BCYC cycle.
REQ-023 BERR  out  1  one-cycle pulse on watchdog abort.

Function
REQ-024 States IDLE, IBUS, DBUS, TURN; encoding free.
REQ-025 IDLE: with DREQ=1 go to DBUS; else with IREQ=1 go to IBUS; else stay.
REQ-026 Both pending in IDLE: DBUS wins unless the last completed cycle was DBUS and IREQ is pending, in which case IBUS wins (alternation, no starvation).
REQ-027 On the IDLE->bus transition, register A={addr[31:2],2'b00}, BE, WR, D_O from the granted port; fetch: BE=4'hF, WR=0, D_O=0.
REQ-028 In IBUS/DBUS: BCYC=1 and A/BE/WR/D_O stay constant.
REQ-029 In IBUS/DBUS with CE=1 and READY=1: the matching ACK is 1 that same cycle (combinational), ID/DD_I equal D_I, next state TURN.
REQ-030 TURN: BCYC=0, lasts exactly one CE cycle, then IDLE; minimum request-to-ack latency is 1 cycle, minimum request spacing 3 cycles.
REQ-031 Outside their own ack cycle, ID and DD_I are 0; DACK on writes still pulses, with DD_I=D_I (don't-care to the requester).
REQ-032 Watchdog counter clears on entry to IBUS/DBUS, increments each CE cycle with READY=0.
REQ-033 When the counter reaches TMO_CYCLES with READY=0: BERR=1 and the matching ACK=1 with data 0 that cycle, next state TURN.
REQ-034 READY=1 in the same cycle the counter reaches TMO_CYCLES: normal completion, BERR=0.
REQ-035 READY is ignored in IDLE and TURN.
REQ-036 IACK and DACK are never both 1; at most one bus cycle is outstanding.
REQ-037 Requests dropped before ACK while in a bus state: cycle still completes on the bus, ACK still pulses.

Reset
REQ-038 RESn=0 at a rising edge: state IDLE, BCYC=0, A=0, D_O=0, BE=0, WR=0, counter 0, alternation flag = last-was-instruction, BERR=0.
REQ-039 IACK=0, DACK=0, ID=0, DD_I=0 while RESn=0.
REQ-040 Reset mid-cycle aborts the bus cycle without ACK or BERR.

Verification
REQ-041 IREQ=1, IA=0x104, READY tied 1 -> BCYC cycle with A=0x104, BE=F; IACK 1 cycle later with ID=D_I; TURN; next fetch starts 3 cycles after the first.
REQ-042 DREQ+IREQ same cycle, DWR=1, DA=0x70, DBE=4'b0011, DD_O=0x9 -> DBUS first (A=0x70, BE=3, WR=1, D_O=9); then IBUS; then DBUS again if both remain pending.
REQ-043 READY low 3 cycles then high, DWR=0 -> DACK on the 4th BCYC cycle, DD_I=D_I; CE low mid-cycle stretches BCYC by exactly that many cycles.
REQ-044 TMO_CYCLES=4, READY held 0 -> BERR and DACK together 4 cycles after BCYC rises, DD_I=0, then TURN, IDLE.
REQ-045 RESn=0 during DBUS -> next cycle BCYC=0, no DACK/BERR; after release, pending DREQ is re-granted from IDLE.

Source files
------------

// File: rtl/v810_biu.sv
// V810-style bus interface unit: arbitrates instruction fetch and data ports onto one
// READY-terminated external word bus, with a watchdog that aborts a stuck bus cycle.
module v810_biu #(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  logic [31:0] IA,
    input  logic        IREQ,
    output logic [31:0] ID,
    output logic        IACK,
    input  logic [31:0] DA,
    input  logic [31:0] DD_O,
    input  logic [3:0]  DBE,
    input  logic        DWR,
    input  logic        DREQ,
    output logic [31:0] DD_I,
    output logic        DACK,
    output logic [31:0] A,
    output logic [31:0] D_O,
    input  logic [31:0] D_I,
    output logic [3:0]  BE,
    output logic        WR,
    output logic        BCYC,
    input  logic        READY,
    output logic        BERR,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a requester raises xREQ with its address/data stable and keeps them until
    // the one-cycle xACK; the external slave ends a bus cycle by asserting READY while BCYC=1.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IBUS = 2'd1,
        S_DBUS = 2'd2,
        S_TURN = 2'd3
    } state_t;

    localparam logic [15:0] TMO = 16'(TMO_CYCLES);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic        r_last_d;
    logic [31:0] r_a;
    logic [31:0] r_do;
    logic [3:0]  r_be;
    logic        r_wr;

    logic        w_pick_i;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_bus;
    logic        w_done;
    logic        w_tmo;
    logic        w_ack;
    logic        w_unused;

    assign w_unused = ^{IA[1:0], DA[1:0]};
    assign w_bus    = (r_state == S_IBUS) || (r_state == S_DBUS);

    always_comb begin
        w_next    = r_state;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        w_done    = 1'b0;
        w_tmo     = 1'b0;
        // Data normally wins, but a fetch goes first right after a data cycle.
        w_pick_i  = IREQ && (!DREQ || r_last_d);
        case (r_state)
            S_IDLE: begin
                if (w_pick_i) begin
                    w_grant_i = 1'b1;
                    w_next    = S_IBUS;
                end else if (DREQ) begin
                    w_grant_d = 1'b1;
                    w_next    = S_DBUS;
                end
            end
            S_IBUS, S_DBUS: begin
                if (READY) begin
                    w_done = 1'b1;
                end else if (r_cnt == TMO) begin
                    w_done = 1'b1;
                    w_tmo  = 1'b1;
                end
                if (w_done) begin
                    w_next = S_TURN;
                end
            end
            S_TURN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_last_d <= 1'b0;
            r_a      <= '0;
            r_do     <= '0;
            r_be     <= '0;
            r_wr     <= 1'b0;
        end else if (CE) begin
            r_state <= w_next;
            if (w_grant_i) begin
                r_a  <= {IA[31:2], 2'b00};
                r_be <= 4'hF;
                r_wr <= 1'b0;
                r_do <= '0;
            end else if (w_grant_d) begin
                r_a  <= {DA[31:2], 2'b00};
                r_be <= DBE;
                r_wr <= DWR;
                r_do <= DD_O;
            end
            if (w_grant_i || w_grant_d) begin
                r_cnt <= '0;
            end else if (w_bus && !READY && !w_done) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_done) begin
                r_last_d <= (r_state == S_DBUS);
            end
        end
    end

    assign w_ack       = w_done && CE && RESn;
    assign IACK        = w_ack && (r_state == S_IBUS);
    assign DACK        = w_ack && (r_state == S_DBUS);
    assign BERR        = w_ack && w_tmo;
    assign ID          = (IACK && !w_tmo) ? D_I : 32'd0;
    assign DD_I        = (DACK && !w_tmo) ? D_I : 32'd0;
    assign A           = r_a;
    assign D_O         = r_do;
    assign BE          = r_be;
    assign WR          = r_wr;
    assign BCYC        = w_bus;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_v810_biu.sv
// Randomized bench for v810_biu: two requesters and a latency-randomizing bus slave, with a
// transaction-level model of arbitration, turnaround and watchdog checked by a negedge monitor.
module tb_v810_biu;

    localparam int TMO = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] d;
    } desc_t;

    logic        CLK = 1'b0;
    logic        RESn = 1'b0;
    logic        CE = 1'b1;
    logic [31:0] IA = '0;
    logic        IREQ = 1'b0;
    logic [31:0] ID;
    logic        IACK;
    logic [31:0] DA = '0;
    logic [31:0] DD_O = '0;
    logic [3:0]  DBE = '0;
    logic        DWR = 1'b0;
    logic        DREQ = 1'b0;
    logic [31:0] DD_I;
    logic        DACK;
    logic [31:0] A;
    logic [31:0] D_O;
    logic [31:0] D_I = '0;
    logic [3:0]  BE;
    logic        WR;
    logic        BCYC;
    logic        READY = 1'b0;
    logic        BERR;
    logic [1:0]  dbg_state;

    v810_biu #(.TMO_CYCLES(TMO)) dut (
        .CLK(CLK), .RESn(RESn), .CE(CE),
        .IA(IA), .IREQ(IREQ), .ID(ID), .IACK(IACK),
        .DA(DA), .DD_O(DD_O), .DBE(DBE), .DWR(DWR), .DREQ(DREQ), .DD_I(DD_I), .DACK(DACK),
        .A(A), .D_O(D_O), .D_I(D_I), .BE(BE), .WR(WR), .BCYC(BCYC), .READY(READY),
        .BERR(BERR), .o_dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    desc_t exp_i_q[$];
    desc_t exp_d_q[$];

    // Reference model state (transaction level).
    bit          started = 1'b0;
    int          owner = 0;            // 0 none, 1 fetch, 2 data
    int          sa_cnt = 1;           // CE cycles off the bus since the last completion
    bit          last_d_done = 1'b0;
    bit          idle_pend = 1'b0;
    bit          idle_i = 1'b0;
    bit          idle_d = 1'b0;
    bit          i_acked = 1'b0;
    bit          d_acked = 1'b0;
    bit          s_active = 1'b0;
    int          s_idx = 0;
    int          s_lat = 0;
    int          n_resets = 0;

    bit          prev_rst = 1'b0;
    bit          prev_ce = 1'b0;
    bit          prev_bcyc = 1'b0;
    bit          prev_done = 1'b0;
    logic [31:0] prev_a = '0;
    logic [31:0] prev_do = '0;
    logic [3:0]  prev_be = '0;
    logic        prev_wr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_fields();
        desc_t e;
        int    n;
        n = (owner == 1) ? exp_i_q.size() : exp_d_q.size();
        if (n == 0) begin
            chk("bus_queue_size", n, 1);
        end else begin
            e = (owner == 1) ? exp_i_q[0] : exp_d_q[0];
            chk("bus_a", A, e.a);
            chk("bus_be", BE, e.be);
            chk("bus_wr", WR, e.wr);
            chk("bus_do", D_O, e.d);
        end
    endtask

    // Monitor / scoreboard: samples mid-cycle, after all inputs for the cycle are settled.
    always @(negedge CLK) begin
        bit done;
        bit berr;
        done = 1'b0;
        berr = 1'b0;
        if (!RESn) begin
            chk("rst_iack", IACK, 0);
            chk("rst_dack", DACK, 0);
            chk("rst_berr", BERR, 0);
            chk("rst_id", ID, 0);
            chk("rst_dd_i", DD_I, 0);
            owner = 0;
            sa_cnt = 1;
            last_d_done = 1'b0;
            idle_pend = 1'b0;
            s_active = 1'b0;
            s_idx = 0;
            if (!IREQ) exp_i_q.delete();
            if (!DREQ) exp_d_q.delete();
            started = 1'b1;
        end else if (started) begin
            if (!prev_rst) begin
                chk("post_rst_bcyc", BCYC, 0);
                chk("post_rst_a", A, 0);
                chk("post_rst_be", BE, 0);
                chk("post_rst_wr", WR, 0);
                chk("post_rst_do", D_O, 0);
            end else if (!prev_ce) begin
                chk("ce_hold_bcyc", BCYC, prev_bcyc);
                chk("ce_hold_a", A, prev_a);
                chk("ce_hold_be", BE, prev_be);
                chk("ce_hold_wr", WR, prev_wr);
                chk("ce_hold_do", D_O, prev_do);
            end else if (prev_bcyc) begin
                chk("bus_end_or_stay", BCYC, !prev_done);
            end else begin
                chk("bus_start", BCYC, idle_pend);
                if (BCYC && idle_pend)
                    owner = (idle_d && !(idle_i && last_d_done)) ? 2 : 1;
            end
            if (BCYC && owner != 0) check_fields();
            if (BCYC && CE && owner != 0) begin
                if (READY) begin
                    done = 1'b1;
                end else if (s_idx == TMO) begin
                    done = 1'b1;
                    berr = 1'b1;
                end
            end
            chk("iack", IACK, done && owner == 1);
            chk("dack", DACK, done && owner == 2);
            chk("berr", BERR, berr);
            chk("id", ID, (done && owner == 1 && !berr) ? D_I : 32'd0);
            chk("dd_i", DD_I, (done && owner == 2 && !berr) ? D_I : 32'd0);
            if (done) begin
                if (owner == 1) begin
                    if (exp_i_q.size() != 0) void'(exp_i_q.pop_front());
                    i_acked = 1'b1;
                end else begin
                    if (exp_d_q.size() != 0) void'(exp_d_q.pop_front());
                    d_acked = 1'b1;
                end
                last_d_done = (owner == 2);
                owner = 0;
                sa_cnt = 0;
                s_active = 1'b0;
                idle_pend = 1'b0;
            end else if (CE && BCYC) begin
                if (!READY) s_idx++;
                idle_pend = 1'b0;
            end else if (CE) begin
                idle_pend = (sa_cnt >= 1) && (IREQ || DREQ);
                idle_i = IREQ;
                idle_d = DREQ;
                sa_cnt++;
            end
        end
        prev_rst  = RESn;
        prev_ce   = CE;
        prev_bcyc = BCYC;
        prev_done = done;
        prev_a    = A;
        prev_do   = D_O;
        prev_be   = BE;
        prev_wr   = WR;
    end

    // One clock of stimulus: reset/CE, bus slave, then both requesters.
    task automatic drive_cycle(input bit allow_new, input bit ce_rand, input bit rst_ok);
        desc_t e;
        @(posedge CLK);
        #1;
        RESn = 1'b1;
        if (rst_ok && BCYC && n_resets < 10 && $urandom_range(0, 30) == 0) begin
            RESn = 1'b0;
            n_resets++;
        end
        CE  = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        D_I = $urandom;
        if (BCYC) begin
            if (!s_active) begin
                s_active = 1'b1;
                s_idx = 0;
                s_lat = $urandom_range(0, TMO + 2);
            end
            READY = (s_idx == s_lat);
        end else begin
            READY = $urandom_range(0, 1);
        end

        if (i_acked) begin
            i_acked = 1'b0;
            IREQ = 1'b0;
        end
        if (IREQ && owner == 1 && $urandom_range(0, 15) == 0) begin
            IREQ = 1'b0;
            IA = $urandom;
        end
        if (!IREQ && exp_i_q.size() == 0 && allow_new && $urandom_range(0, 2) == 0) begin
            IA = $urandom;
            IREQ = 1'b1;
            e.a = {IA[31:2], 2'b00};
            e.be = 4'hF;
            e.wr = 1'b0;
            e.d = '0;
            exp_i_q.push_back(e);
        end

        if (d_acked) begin
            d_acked = 1'b0;
            DREQ = 1'b0;
        end
        if (DREQ && owner == 2 && $urandom_range(0, 15) == 0) begin
            DREQ = 1'b0;
            DA = $urandom;
            DD_O = $urandom;
        end
        if (!DREQ && exp_d_q.size() == 0 && allow_new && $urandom_range(0, 2) == 0) begin
            DA = $urandom;
            DD_O = $urandom;
            DBE = 4'($urandom_range(0, 15));
            DWR = $urandom_range(0, 1);
            DREQ = 1'b1;
            e.a = {DA[31:2], 2'b00};
            e.be = DBE;
            e.wr = DWR;
            e.d = DD_O;
            exp_d_q.push_back(e);
        end
    endtask

    initial begin
        int waited;
        repeat (3) @(posedge CLK);
        for (int c = 0; c < 1000; c++) drive_cycle(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 1500; c++) drive_cycle(1'b1, 1'b1, 1'b1);
        for (int c = 0; c < 500; c++)  drive_cycle(1'b1, 1'b0, 1'b1);
        waited = 0;
        while ((exp_i_q.size() != 0 || exp_d_q.size() != 0 || IREQ || DREQ) && waited < 400) begin
            drive_cycle(1'b0, 1'b0, 1'b0);
            waited++;
        end
        chk("drain_outstanding", exp_i_q.size() + exp_d_q.size(), 0);
        repeat (2) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
